los_packet_loader: RTL

- Upstream feeder for the LOS telemetry buffer block.
- Accepts a packet of 32-bit words on a valid/ready stream and writes it into the 2048x32 telemetry RAM through that block's data/burst-address interface.
- Frames each packet with a 0xF00D header at address 0 and a checksum trailer.
- Drives the buffer's control register to reset, start and acknowledge transmission, one packet at a time.

---
 rtl/los_pkg.sv | 39 +++
 rtl/los_packet_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/los_pkg.sv
// Shared constants and state encoding for the LOS packet loader and the
// telemetry buffer it feeds.
package los_pkg;

    // Control register bit patterns understood by the buffer block.
    localparam logic [31:0] LOS_CTRL_RESET = 32'h0000_0001;
    localparam logic [31:0] LOS_CTRL_SEND  = 32'h0000_0002;
    localparam logic [31:0] LOS_CTRL_IRQ   = 32'h0000_0004;

    // Header marker placed in the low half of RAM word 0.
    localparam logic [15:0] LOS_MAGIC = 16'hF00D;

    // Telemetry RAM address width (2048 words).
    localparam int LOS_BUF_AW = 11;

    // Payload words that fit between header (addr 0) and trailer.
    localparam int LOS_MAX_WORDS = (1 << LOS_BUF_AW) - 2;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CLR   = 4'd1,
        ST_CLRW  = 4'd2,
        ST_SEEK  = 4'd3,
        ST_DATA  = 4'd4,
        ST_TRL   = 4'd5,
        ST_HSEEK = 4'd6,
        ST_HDR   = 4'd7,
        ST_START = 4'd8,
        ST_WAIT  = 4'd9,
        ST_ACK   = 4'd10
    } los_state_e;

    // Header word: payload length in the high half, magic in the low half.
    function automatic logic [31:0] los_header(input logic [15:0] len,
                                               input logic [15:0] magic);
        return {len, magic};
    endfunction

endpackage

// File: rtl/los_packet_loader.sv
// LOS packet loader: takes a valid/ready stream of 32-bit payload words,
// frames it with a header at RAM address 0 and a two's-complement checksum
// trailer, and drives the buffer's control register through reset, send and
// interrupt acknowledge for each packet.
module los_packet_loader
    import los_pkg::*;
#(
    parameter int          MAX_WORDS = LOS_MAX_WORDS,
    parameter logic [15:0] MAGIC     = LOS_MAGIC
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           s_dat_i,
    input  logic                  s_valid_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    output logic                  buf_wr_o,
    output logic [31:0]           buf_dat_o,
    output logic [LOS_BUF_AW-1:0] buf_addr_o,
    output logic                  buf_addr_wr_o,
    output logic                  ctrl_wr_o,
    output logic [31:0]           ctrl_dat_o,
    input  logic                  interrupt_i,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic [15:0]           pkt_count_o
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    los_state_e            r_state;
    los_state_e            w_state_nxt;
    logic [15:0]           r_len;
    logic [31:0]           r_csum;
    logic                  r_ovf;
    logic [15:0]           r_pkt_cnt;
    logic                  r_s_ready;
    logic                  r_buf_wr;
    logic [31:0]           r_buf_dat;
    logic [LOS_BUF_AW-1:0] r_buf_addr;
    logic                  r_addr_wr;
    logic                  r_ctrl_wr;
    logic [31:0]           r_ctrl_dat;

    logic                  w_hs;
    logic                  w_pay_wr;
    logic [31:0]           w_csum_nxt;

    // A payload word is written in its handshake cycle; words beyond the
    // capacity are still accepted so the stream drains, but not stored.
    assign w_hs       = r_s_ready & s_valid_i;
    assign w_pay_wr   = w_hs & (r_len < MAX_LEN);
    assign w_csum_nxt = w_pay_wr ? (r_csum + s_dat_i) : r_csum;

    // Next-state decode for the packet sequence.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (s_valid_i) w_state_nxt = ST_CLR;
            ST_CLR:   w_state_nxt = ST_CLRW;
            ST_CLRW:  w_state_nxt = ST_SEEK;
            ST_SEEK:  w_state_nxt = ST_DATA;
            ST_DATA:  if (w_hs && s_last_i) w_state_nxt = ST_TRL;
            ST_TRL:   w_state_nxt = ST_HSEEK;
            ST_HSEEK: w_state_nxt = ST_HDR;
            ST_HDR:   w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (interrupt_i) w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs; outputs are loaded with the
    // values belonging to the state being entered so they line up with it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_csum     <= '0;
            r_ovf      <= 1'b0;
            r_pkt_cnt  <= '0;
            r_s_ready  <= 1'b0;
            r_buf_wr   <= 1'b0;
            r_buf_dat  <= '0;
            r_buf_addr <= '0;
            r_addr_wr  <= 1'b0;
            r_ctrl_wr  <= 1'b0;
            r_ctrl_dat <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
            r_state    <= w_state_nxt;
            r_s_ready  <= 1'b0;
            r_buf_wr   <= 1'b0;
            r_buf_dat  <= '0;
            r_buf_addr <= '0;
            r_addr_wr  <= 1'b0;
            r_ctrl_wr  <= 1'b0;
            r_ctrl_dat <= '0;

            if (w_state_nxt == ST_CLR) begin
                r_len  <= '0;
                r_csum <= '0;
                r_ovf  <= 1'b0;
            end else if (w_hs) begin
                if (w_pay_wr) begin
                    r_len  <= r_len + 16'd1;
                    r_csum <= w_csum_nxt;
                end else begin
                    r_ovf  <= 1'b1;
                end
            end

            unique case (w_state_nxt)
                ST_CLR: begin
                    r_ctrl_wr  <= 1'b1;
                    r_ctrl_dat <= LOS_CTRL_RESET;
                end
                ST_SEEK: begin
                    r_addr_wr  <= 1'b1;
                    r_buf_addr <= LOS_BUF_AW'(1);
                end
                ST_DATA: begin
                    r_s_ready  <= 1'b1;
                end
                ST_TRL: begin
                    // Trailer makes payload plus trailer sum to zero.
                    r_buf_wr   <= 1'b1;
                    r_buf_dat  <= 32'd0 - w_csum_nxt;
                end
                ST_HSEEK: begin
                    r_addr_wr  <= 1'b1;
                    r_buf_addr <= '0;
                end
                ST_HDR: begin
                    r_buf_wr   <= 1'b1;
                    r_buf_dat  <= los_header(r_len, MAGIC);
                end
                ST_START: begin
                    r_ctrl_wr  <= 1'b1;
                    r_ctrl_dat <= LOS_CTRL_SEND;
                end
                ST_ACK: begin
                    r_ctrl_wr  <= 1'b1;
                    r_ctrl_dat <= '0;
                    r_pkt_cnt  <= r_pkt_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign s_ready_o     = r_s_ready;
    assign buf_wr_o      = r_buf_wr | w_pay_wr;
    assign buf_dat_o     = w_pay_wr ? s_dat_i : r_buf_dat;
    assign buf_addr_o    = r_buf_addr;
    assign buf_addr_wr_o = r_addr_wr;
    assign ctrl_wr_o     = r_ctrl_wr;
    assign ctrl_dat_o    = r_ctrl_dat;
    assign busy_o        = (r_state != ST_IDLE);
    assign overflow_o    = r_ovf;
    assign pkt_count_o   = r_pkt_cnt;

endmodule
